// File: rtl/dpram_burst_pkg.sv
// rtl/dpram_burst_pkg.sv - shared state encoding and defaults for the burst sequencer
package dpram_burst_pkg;

    localparam int LENW_DEFAULT = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2
    } state_t;

endpackage

// File: rtl/dpram_burst_ctrl_if.sv
// rtl/dpram_burst_ctrl_if.sv - request, write-data, response and RAM-port bundle
interface dpram_burst_ctrl_if
    import dpram_burst_pkg::*;
#(
    parameter int AWIDTH = 10,
    parameter int DWIDTH = 32,
    parameter int LENW   = LENW_DEFAULT
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [AWIDTH-1:0]     req_addr;
    logic [LENW-1:0]       req_len;

    logic                  wd_valid;
    logic                  wd_ready;
    logic [DWIDTH-1:0]     wd_data;
    logic [DWIDTH/8-1:0]   wd_byteen;
    logic                  wr_done;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DWIDTH-1:0]     rsp_data;
    logic                  rsp_last;

    logic [AWIDTH-1:0]     ram_address;
    logic                  ram_wren;
    logic [DWIDTH/8-1:0]   ram_byteen;
    logic [DWIDTH-1:0]     ram_data;
    logic [DWIDTH-1:0]     ram_out;

    // Controller side
    modport slave (
        input  req_valid, req_we, req_addr, req_len,
        output req_ready,
        input  wd_valid, wd_data, wd_byteen,
        output wd_ready, wr_done,
        input  rsp_ready,
        output rsp_valid, rsp_data, rsp_last,
        output ram_address, ram_wren, ram_byteen, ram_data,
        input  ram_out
    );

    // Requester / RAM side
    modport master (
        output req_valid, req_we, req_addr, req_len,
        input  req_ready,
        output wd_valid, wd_data, wd_byteen,
        input  wd_ready, wr_done,
        output rsp_ready,
        input  rsp_valid, rsp_data, rsp_last,
        input  ram_address, ram_wren, ram_byteen, ram_data,
        output ram_out
    );

endinterface

// File: rtl/dpram_rsp_fifo.sv
// rtl/dpram_rsp_fifo.sv - read-response FIFO (data + last tag) with occupancy count
module dpram_rsp_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO is only taken when the head leaves on the same edge
    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != FULL) || do_pop);

    // Head is forced to zero while empty so stale entries never reach the outputs
    assign pop_data = (count != '0) ? mem[rd_ptr] : '0;

    // Storage array write
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/dpram_burst_ctrl.sv
// rtl/dpram_burst_ctrl.sv - burst sequencer driving one port of a 1-cycle-latency word RAM
module dpram_burst_ctrl
    import dpram_burst_pkg::*;
#(
    parameter int AWIDTH    = 10,
    parameter int DWIDTH    = 32,
    parameter int LENW      = LENW_DEFAULT,
    parameter int RSP_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    dpram_burst_ctrl_if.slave bus
);
    localparam int CW = $clog2(RSP_DEPTH) + 1;

    state_t            state;
    state_t            state_nxt;
    logic [AWIDTH-1:0] cur;
    logic [LENW-1:0]   beats_left;
    logic              inflight;
    logic              inflight_last;
    logic              wr_done_q;
    logic [CW-1:0]     fifo_count;
    logic [DWIDTH:0]   fifo_dout;
    logic              credit_ok;
    logic              rd_issue;
    logic              wr_beat;
    logic              last_beat;
    logic              accept;

    // Credits count both queued data and the beat still in the RAM pipeline,
    // so rsp_ready never reaches the RAM port combinationally.
    assign credit_ok = ({1'b0, fifo_count} + (CW+1)'(inflight)) < (CW+1)'(RSP_DEPTH);
    assign last_beat = (beats_left == '0);
    assign accept    = bus.req_ready && bus.req_valid;

    assign bus.ram_address = cur;
    assign bus.wr_done     = wr_done_q;
    assign bus.rsp_valid   = (fifo_count != '0);
    assign bus.rsp_data    = fifo_dout[DWIDTH-1:0];
    assign bus.rsp_last    = fifo_dout[DWIDTH];

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Next state, handshakes and RAM write-side drive
    always_comb begin
        state_nxt      = state;
        bus.req_ready  = 1'b0;
        bus.wd_ready   = 1'b0;
        bus.ram_wren   = 1'b0;
        bus.ram_byteen = '0;
        bus.ram_data   = '0;
        rd_issue       = 1'b0;
        wr_beat        = 1'b0;
        case (state)
            ST_IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) state_nxt = bus.req_we ? ST_WR : ST_RD;
            end
            ST_RD: begin
                rd_issue = credit_ok;
                if (credit_ok && last_beat) state_nxt = ST_IDLE;
            end
            ST_WR: begin
                bus.wd_ready = 1'b1;
                wr_beat      = bus.wd_valid;
                if (bus.wd_valid) begin
                    bus.ram_wren   = 1'b1;
                    bus.ram_byteen = bus.wd_byteen;
                    bus.ram_data   = bus.wd_data;
                    if (last_beat) state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Burst address/beat tracking, read pipeline tag and write-complete pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur           <= '0;
            beats_left    <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            wr_done_q     <= 1'b0;
        end else begin
            inflight      <= rd_issue;
            inflight_last <= rd_issue && last_beat;
            wr_done_q     <= wr_beat && last_beat;
            if (accept) begin
                cur        <= bus.req_addr;
                beats_left <= bus.req_len;
            end else if (rd_issue || wr_beat) begin
                cur        <= cur + 1'b1;
                beats_left <= beats_left - 1'b1;
            end
        end
    end

    dpram_rsp_fifo #(
        .WIDTH (DWIDTH + 1),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (inflight),
        .push_data ({inflight_last, bus.ram_out}),
        .pop       (bus.rsp_valid && bus.rsp_ready),
        .pop_data  (fifo_dout),
        .count     (fifo_count)
    );

endmodule

// File: doc/dpram_burst_ctrl.md
Name: dpram_burst_ctrl

Overview:
Burst sequencer that sits directly upstream of one port of the dual-port word RAM (dpram1). It accepts burst read/write requests over valid/ready, expands each into consecutive word accesses on the RAM port, and returns read data through a response FIFO. The RAM has 1-cycle read latency and supports byte-enabled writes.

Parameters:
AWIDTH, 10, RAM word-address width; matches the RAM port address.
DWIDTH, 32, data width; must be a multiple of 32.
LENW, 4, burst-length field width; maximum burst is 2^LENW beats.
RSP_DEPTH, 4, response FIFO entries; must be a power of 2 and at least 2.

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset  in  1  asynchronous, active-high reset.
req_valid  in  1  burst request valid.
req_ready  out  1  request accepted on the edge where valid and ready are both high.
req_we  in  1  1 = write burst, 0 = read burst.
req_addr  in  AWIDTH  start word address.
req_len  in  LENW  number of beats minus 1.
wd_valid  in  1  write beat valid.
wd_ready  out  1  write beat consumed.
wd_data  in  DWIDTH  write data.
wd_byteen  in  DWIDTH/8  byte enables, passed to the RAM unchanged.
wr_done  out  1  1-cycle pulse after the last write beat.
rsp_valid  out  1  read beat valid.
rsp_ready  in  1  consumer accepts a read beat.
rsp_data  out  DWIDTH  read data.
rsp_last  out  1  marks the final beat of a burst.
ram_address  out  AWIDTH  to RAM address port.
ram_wren  out  1  to RAM write-enable port.
ram_byteen  out  DWIDTH/8  to RAM byte-enable port.
ram_data  out  DWIDTH  to RAM write-data port.
ram_out  in  DWIDTH  RAM read data; valid the cycle after the address is issued with ram_wren=0.

Behaviour:
- States: IDLE, RD, WR.
- Reset (async) forces IDLE; clears the FIFO, in-flight flag and counters.
  - Reset values: req_ready=1, wd_ready=0, wr_done=0, rsp_valid=0, rsp_last=0, ram_wren=0, ram_address=0, ram_byteen=0, ram_data=0, rsp_data=0.
  - A reset mid-burst drops the burst and any queued responses with no further output.
- req_ready=1 only in IDLE. On acceptance: latch addr, len and we; go to RD or WR.
- RD: each cycle a beat issues (ram_address=cur, ram_wren=0) only if fifo_count + inflight < RSP_DEPTH.
  - On issue: cur increments; beat counter decrements.
  - inflight is a registered flag set on issue. On the next edge ram_out and its last-tag are pushed into the FIFO.
  - After issuing the last beat, return to IDLE. Outstanding data still drains from the FIFO.
  - No combinational path from rsp_ready to the RAM outputs.
- Read latency: acceptance on edge E0, first address at E1, FIFO push at E2, rsp_valid high after E2.
  - With rsp_ready held high: 1 beat per cycle, no bubbles.
- Response ordering is strictly address order. rsp_last=1 on beat len only.
- WR: wd_ready=1 throughout WR.
  - On a cycle with wd_valid: ram_wren=1, ram_address=cur, ram_data=wd_data, ram_byteen=wd_byteen; cur increments.
  - ram_wren=0 on cycles without wd_valid.
  - After the last beat: wr_done pulses for 1 cycle on the next cycle; return to IDLE.
- Byte-enable mapping belongs to the RAM: wd_byteen[DWIDTH/8-1-(4k+i)] enables data bits [32k+8i +: 8]. This block never reorders it.
- Address arithmetic is modulo 2^AWIDTH: a burst crossing the top address wraps to 0.
- The RAM outputs (ram_address, ram_wren, ram_byteen, ram_data) are driven combinationally from registered state and the input handshake; no output glitches are permitted across the edge.
- A new request is accepted in IDLE even while the FIFO still holds data from a previous burst.
  - Issue credits account for that data; read order across bursts is preserved.
- FIFO full with rsp_ready=0: issuing stalls and nothing is lost or duplicated.

Decomposition:
- Shared package dpram_burst_pkg: state encoding constants (ST_IDLE, ST_RD, ST_WR) and the LENW default.
- One sub-module, dpram_rsp_fifo: synchronous FIFO of width DWIDTH+1 (data + last) with count output.
  - Push and pop in the same cycle are allowed when full or empty-with-push.

Test Plan:
- Single read: RAM[0x010]=0xDEADBEEF, read burst addr 0x010, len 0 -> rsp_valid 2 cycles after acceptance, rsp_data=0xDEADBEEF, rsp_last=1.
- Burst read: addr 0x020, len 3, rsp_ready=1 -> 4 consecutive beats from 0x020..0x023; rsp_last only on the 4th.
- Backpressure: len 7, rsp_ready low for cycles 3-8 -> ram issue stops when the FIFO is full; all 8 beats delivered in order with none lost.
- Partial write: addr 0x005, data 0x11223344, byteen 4'b1000, RAM preset 0xAAAAAAAA -> RAM[0x005]=0xAAAAAA44; wr_done pulses once.
- Wrap: addr 0x3FE, len 3 write then read -> RAM words 0x3FE, 0x3FF, 0x000, 0x001 written and read back identically.
- Reset mid-burst: assert reset during beat 2 of a len-7 read -> outputs immediately at reset values; next request behaves normally.
